// File: rtl/pic_irq_core.sv
// pic_irq_core: 8259-style interrupt controller core with IRR/IMR/ISR, a rotating priority resolver,
// a two-pulse INTA sequencer and EOI/AEOI handling. Define PIC_POLL_MODE_EN to enable poll-mode acknowledge.
//
// state  | meaning
// S_IDLE | no request presented to the CPU; waiting for an eligible candidate
// S_REQ  | int_out high, waiting for the first inta (winner latched there)
// S_ACK2 | waiting for the second inta, which drives the vector
module pic_irq_core #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ),
    parameter int VEC_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic               rd_en,
    input  logic [1:0]         rd_addr,
    output logic [31:0]        rd_data,
    input  logic               inta,
    output logic               int_out,
    output logic [VEC_W-1:0]   vec_out,
    output logic               vec_valid,
    output logic               eoi_pulse
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK2} state_t;

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_irr, r_isr, r_imr, r_irq_prev;
    logic [VEC_W-1:0]   r_base;
    logic [2:0]         r_mode;
    logic [ID_W-1:0]    r_prio, r_id;
    logic               r_spur;
    logic               r_int_out, r_vec_valid, r_eoi_pulse;
    logic [VEC_W-1:0]   r_vec_out;
    logic [31:0]        r_rd_data;

    logic [NUM_IRQ-1:0] w_pend, w_isr_clr, w_isr_set, w_irr_clr, w_isr_nxt, w_irr_nxt;
    logic               w_cand_vld, w_isr_vld, w_clr_vld, w_cmd, w_ack, w_poll_ack;
    logic [ID_W-1:0]    w_cand_id, w_isr_id, w_clr_id, w_sid, w_idx;
    logic [31:0]        w_poll_data;
    logic               w_unused;
    int                 w_k;

    function automatic logic [ID_W-1:0] f_next(input logic [ID_W-1:0] id);
        return (int'(id) == NUM_IRQ - 1) ? '0 : id + 1'b1;
    endfunction

    assign w_pend   = r_irr & ~r_imr;
    assign w_cmd    = wr_en && (wr_addr == 2'd2);
    assign w_sid    = wr_data[8 +: ID_W];
    assign w_unused = ^{wr_data, r_base[ID_W-1:0]};

    // Scan from prio_base downward in priority; a candidate only counts if found before any ISR bit.
    always_comb begin
        w_cand_vld = 1'b0;
        w_cand_id  = '0;
        w_isr_vld  = 1'b0;
        w_isr_id   = '0;
        w_k        = 0;
        w_idx      = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_k = int'(r_prio) + i;
            if (w_k >= NUM_IRQ) w_k = w_k - NUM_IRQ;
            w_idx = ID_W'(w_k);
            if (r_isr[w_idx] && !w_isr_vld) begin
                w_isr_vld = 1'b1;
                w_isr_id  = w_idx;
            end
            if (w_pend[w_idx] && !w_isr_vld && !w_cand_vld) begin
                w_cand_vld = 1'b1;
                w_cand_id  = w_idx;
            end
        end
    end

`ifdef PIC_POLL_MODE_EN
    assign w_poll_ack  = rd_en && (rd_addr == 2'd3) && (r_state == S_IDLE) && w_cand_vld;
    assign w_poll_data = (r_state == S_IDLE && w_cand_vld) ? {1'b1, 31'(w_cand_id)} : 32'd0;
`else
    assign w_poll_ack  = 1'b0;
    assign w_poll_data = 32'd0;
`endif

    assign w_ack = (r_state == S_REQ) && inta && w_cand_vld;

    always_comb begin
        w_isr_clr = '0;
        w_isr_set = '0;
        w_irr_clr = '0;
        w_clr_vld = 1'b0;
        w_clr_id  = '0;
        if (w_cmd && wr_data[0] && w_isr_vld) begin
            w_isr_clr[w_isr_id] = 1'b1;
            w_clr_vld = 1'b1;
            w_clr_id  = w_isr_id;
        end
        if (w_cmd && wr_data[1] && int'(w_sid) < NUM_IRQ && r_isr[w_sid]) begin
            w_isr_clr[w_sid] = 1'b1;
            w_clr_vld = 1'b1;
            w_clr_id  = w_sid;
        end
        if (r_state == S_ACK2 && inta && r_mode[1] && !r_spur && r_isr[r_id]) begin
            w_isr_clr[r_id] = 1'b1;
            w_clr_vld = 1'b1;
            w_clr_id  = r_id;
        end
        if (w_ack) begin
            w_isr_set[w_cand_id] = 1'b1;
            w_irr_clr[w_cand_id] = 1'b1;
        end
        // A polled acknowledge under AEOI sets and clears ISR in one step, so ISR never holds it.
        if (w_poll_ack) begin
            w_irr_clr[w_cand_id] = 1'b1;
            if (r_mode[1]) begin
                w_clr_vld = 1'b1;
                w_clr_id  = w_cand_id;
            end else begin
                w_isr_set[w_cand_id] = 1'b1;
            end
        end
        w_isr_nxt = (r_isr & ~w_isr_clr) | w_isr_set;
        w_irr_nxt = r_mode[0] ? (irq_in & ~w_isr_nxt)
                              : ((r_irr & ~w_irr_clr) | (irq_in & ~r_irq_prev));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_irr       <= '0;
            r_isr       <= '0;
            r_imr       <= '0;
            r_irq_prev  <= '0;
            r_base      <= '0;
            r_mode      <= '0;
            r_prio      <= '0;
            r_id        <= '0;
            r_spur      <= 1'b0;
            r_int_out   <= 1'b0;
            r_vec_out   <= '0;
            r_vec_valid <= 1'b0;
            r_eoi_pulse <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_irq_prev  <= irq_in;
            r_irr       <= w_irr_nxt;
            r_isr       <= w_isr_nxt;
            r_eoi_pulse <= w_clr_vld;
            r_vec_valid <= 1'b0;

            if (wr_en) begin
                case (wr_addr)
                    2'd0:    r_imr  <= wr_data[NUM_IRQ-1:0];
                    2'd1:    r_base <= wr_data[VEC_W-1:0];
                    2'd3:    r_mode <= wr_data[2:0];
                    default: ;
                endcase
            end

            if (w_cmd && wr_data[2]) r_prio <= w_sid;
            else if (r_mode[2] && w_clr_vld) r_prio <= f_next(w_clr_id);

            if (rd_en) begin
                case (rd_addr)
                    2'd0:    r_rd_data <= 32'(r_irr);
                    2'd1:    r_rd_data <= 32'(r_isr);
                    2'd2:    r_rd_data <= 32'(r_imr);
                    default: r_rd_data <= w_poll_data;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cand_vld && !w_poll_ack) begin
                        r_state   <= S_REQ;
                        r_int_out <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (inta) begin
                        r_state <= S_ACK2;
                        r_spur  <= !w_cand_vld;
                        r_id    <= w_cand_vld ? w_cand_id : ID_W'(NUM_IRQ - 1);
                    end
                end
                S_ACK2: begin
                    if (inta) begin
                        r_state     <= S_IDLE;
                        r_vec_out   <= {r_base[VEC_W-1:ID_W], r_id};
                        r_vec_valid <= 1'b1;
                        r_int_out   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_data   = r_rd_data;
    assign int_out   = r_int_out;
    assign vec_out   = r_vec_out;
    assign vec_valid = r_vec_valid;
    assign eoi_pulse = r_eoi_pulse;

endmodule

// File: tb/tb_pic_irq_core.sv
// Testbench for pic_irq_core: directed scenarios plus randomized service runs against a rank-based model.
module tb_pic_irq_core;
    localparam int N  = 8;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  irq_in = '0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          rd_en = 1'b0;
    logic [1:0]    rd_addr = '0;
    logic [31:0]   rd_data;
    logic          inta = 1'b0;
    logic          int_out;
    logic [VW-1:0] vec_out;
    logic          vec_valid;
    logic          eoi_pulse;

    int total = 0;
    int bad   = 0;
    int eoi_cnt = 0;
    int vv_cnt  = 0;

    logic [N-1:0] m_irr, m_isr, m_imr;
    int           m_prio, m_base;
    bit           m_aeoi, m_rot;

    pic_irq_core #(.NUM_IRQ(N), .VEC_W(VW)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .inta(inta), .int_out(int_out), .vec_out(vec_out),
        .vec_valid(vec_valid), .eoi_pulse(eoi_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (eoi_pulse) eoi_cnt++;
        if (vec_valid) vv_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; irq_in = '0; wr_en = 1'b0; rd_en = 1'b0; inta = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0; wr_data = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic pulse_irq(input logic [N-1:0] m);
        irq_in = m;
        @(negedge clk);
        irq_in = '0;
    endtask

    task automatic ack();
        inta = 1'b1;
        @(negedge clk);
        inta = 1'b0;
    endtask

    task automatic wait_int(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= max; i++) begin
            if (int_out) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Model: rank 0 is the highest priority; rank = distance from prio_base.
    function automatic int m_rank(input int id);
        return (id - m_prio + N) % N;
    endfunction

    function automatic int m_best();
        int best = -1, br = N, ir = N;
        for (int i = 0; i < N; i++) begin
            if (m_isr[i] && m_rank(i) < ir) ir = m_rank(i);
            if (m_irr[i] && !m_imr[i] && m_rank(i) < br) begin
                br = m_rank(i);
                best = i;
            end
        end
        return (best >= 0 && br < ir) ? best : -1;
    endfunction

    task automatic m_clear(input int id);
        m_isr[id] = 1'b0;
        if (m_rot) m_prio = (id + 1) % N;
    endtask

    task automatic m_eoi_ns();
        int best = -1, br = N;
        for (int i = 0; i < N; i++)
            if (m_isr[i] && m_rank(i) < br) begin
                br = m_rank(i);
                best = i;
            end
        if (best >= 0) m_clear(best);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        tick(2);
        total++;
        if ({int_out, vec_valid, eoi_pulse, vec_out, rd_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got int=%b vv=%b eoi=%b vec=%h rd=%h want all 0",
                     int_out, vec_valid, eoi_pulse, vec_out, rd_data);
        end
        rst_n = 1'b1;
        tick(1);
        rd(2'd0, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL reset_irr: got %h want 0", d); end
        rd(2'd1, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL reset_isr: got %h want 0", d); end
        rd(2'd2, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL reset_imr: got %h want 0", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        bit ok;
        int v0;
        do_reset();
        wr(2'd1, 32'h40);
        pulse_irq(8'h08);
        wait_int(2, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_int: got int_out=0 want 1 within 2 cycles"); end
        v0 = vv_cnt;
        ack();
        ack();
        total++;
        if (vec_out !== 8'h43 || vec_valid !== 1'b1) begin
            bad++; $display("FAIL basic_vec: got vec=%h vv=%b want vec=43 vv=1", vec_out, vec_valid);
        end
        total++;
        if (int_out !== 1'b0) begin bad++; $display("FAIL basic_int_drop: got %b want 0", int_out); end
        tick(2);
        total++;
        if (vv_cnt - v0 != 1) begin bad++; $display("FAIL basic_vv_once: got %0d pulses want 1", vv_cnt - v0); end
        rd(2'd1, d);
        total++;
        if (d !== 32'h08) begin bad++; $display("FAIL basic_isr: got %h want 08", d); end
        rd(2'd0, d);
        total++;
        if (d !== 32'h00) begin bad++; $display("FAIL basic_irr: got %h want 00", d); end
    endtask

    task automatic test_nested_eoi();
        logic [31:0] d;
        bit ok, hi;
        do_reset();
        pulse_irq(8'h24);
        wait_int(3, ok);
        ack();
        ack();
        total++;
        if (!ok || vec_out !== 8'h02) begin bad++; $display("FAIL eoi_first: got ok=%b vec=%h want vec=02", ok, vec_out); end
        hi = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(1); hi |= int_out; end
        total++;
        if (hi) begin bad++; $display("FAIL eoi_holdoff: got int_out=1 want 0 while ISR[2] set"); end
        wr(2'd2, 32'h1);
        wait_int(3, ok);
        ack();
        ack();
        total++;
        if (!ok || vec_out !== 8'h05) begin bad++; $display("FAIL eoi_second: got ok=%b vec=%h want vec=05", ok, vec_out); end
        wr(2'd2, 32'h1);
        rd(2'd1, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL eoi_isr_clear: got %h want 0", d); end
    endtask

    task automatic test_mask();
        bit ok;
        do_reset();
        wr(2'd0, 32'h10);
        pulse_irq(8'h10);
        tick(4);
        total++;
        if (int_out !== 1'b0) begin bad++; $display("FAIL mask_hold: got int_out=%b want 0", int_out); end
        wr(2'd0, 32'h0);
        wait_int(3, ok);
        ack();
        ack();
        total++;
        if (!ok || vec_out !== 8'h04) begin bad++; $display("FAIL mask_release: got ok=%b vec=%h want vec=04", ok, vec_out); end
    endtask

    task automatic test_rotate_aeoi();
        logic [31:0] d;
        bit ok;
        int e0;
        do_reset();
        wr(2'd3, 32'h6);
        pulse_irq(8'h40);
        wait_int(3, ok);
        e0 = eoi_cnt;
        ack();
        ack();
        total++;
        if (!ok || vec_out !== 8'h06) begin bad++; $display("FAIL rot_vec6: got ok=%b vec=%h want vec=06", ok, vec_out); end
        tick(2);
        total++;
        if (eoi_cnt - e0 != 1) begin bad++; $display("FAIL rot_eoi: got %0d pulses want 1", eoi_cnt - e0); end
        rd(2'd1, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL rot_isr: got %h want 0", d); end
        pulse_irq(8'h81);
        wait_int(3, ok);
        ack();
        ack();
        total++;
        if (!ok || vec_out !== 8'h07) begin bad++; $display("FAIL rot_first7: got ok=%b vec=%h want vec=07", ok, vec_out); end
        wait_int(3, ok);
        ack();
        ack();
        total++;
        if (!ok || vec_out !== 8'h00) begin bad++; $display("FAIL rot_then0: got ok=%b vec=%h want vec=00", ok, vec_out); end
    endtask

    task automatic test_nested();
        logic [31:0] d;
        bit ok, hi;
        do_reset();
        pulse_irq(8'h02);
        wait_int(3, ok);
        ack();
        ack();
        total++;
        if (!ok || vec_out !== 8'h01) begin bad++; $display("FAIL nest_vec1: got ok=%b vec=%h want vec=01", ok, vec_out); end
        pulse_irq(8'h01);
        wait_int(3, ok);
        ack();
        ack();
        total++;
        if (!ok || vec_out !== 8'h00) begin bad++; $display("FAIL nest_vec0: got ok=%b vec=%h want vec=00", ok, vec_out); end
        rd(2'd1, d);
        total++;
        if (d !== 32'h03) begin bad++; $display("FAIL nest_isr: got %h want 03", d); end
        pulse_irq(8'h02);
        rd(2'd0, d);
        total++;
        if (d !== 32'h02) begin bad++; $display("FAIL nest_irr: got %h want 02", d); end
        wr(2'd2, 32'h0000_0002);
        hi = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(1); hi |= int_out; end
        total++;
        if (hi) begin bad++; $display("FAIL nest_blocked: got int_out=1 want 0 with ISR[1] set"); end
        wr(2'd2, 32'h1);
        wait_int(3, ok);
        ack();
        ack();
        total++;
        if (!ok || vec_out !== 8'h01) begin bad++; $display("FAIL nest_reserve1: got ok=%b vec=%h want vec=01", ok, vec_out); end
    endtask

    task automatic test_spurious();
        logic [31:0] d;
        bit ok;
        do_reset();
        pulse_irq(8'h08);
        wait_int(3, ok);
        wr(2'd0, 32'h08);
        ack();
        ack();
        total++;
        if (!ok || vec_out !== 8'(N - 1)) begin bad++; $display("FAIL spur_vec: got ok=%b vec=%h want vec=%h", ok, vec_out, 8'(N - 1)); end
        rd(2'd1, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL spur_isr: got %h want 0", d); end
        rd(2'd0, d);
        total++;
        if (d !== 32'h08) begin bad++; $display("FAIL spur_irr: got %h want 08", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit ok;
        int v0;
        do_reset();
        pulse_irq(8'h01);
        wait_int(3, ok);
        ack();
        v0 = vv_cnt;
        rst_n = 1'b0;
        tick(1);
        total++;
        if (int_out !== 1'b0 || vec_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_out: got int=%b vv=%b want 0 0", int_out, vec_valid);
        end
        rst_n = 1'b1;
        tick(1);
        ack();
        tick(2);
        total++;
        if (vv_cnt != v0) begin bad++; $display("FAIL midrst_vv: got %0d pulses want 0", vv_cnt - v0); end
        rd(2'd1, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL midrst_isr: got %h want 0", d); end
    endtask

    task automatic test_poll();
        logic [31:0] d;
        bit hi;
        do_reset();
        pulse_irq(8'h04);
        hi = int_out;
        rd(2'd3, d);
`ifdef PIC_POLL_MODE_EN
        total++;
        if (d !== 32'h8000_0002) begin bad++; $display("FAIL poll_data: got %h want 80000002", d); end
        for (int i = 0; i < 4; i++) begin hi |= int_out; tick(1); end
        total++;
        if (hi) begin bad++; $display("FAIL poll_noint: got int_out=1 want 0"); end
        rd(2'd1, d);
        total++;
        if (d !== 32'h04) begin bad++; $display("FAIL poll_isr: got %h want 04", d); end
`else
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL poll_off: got %h want 0", d); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [N-1:0] edges;
        bit ok;
        int id, expv, e0;
        do_reset();
        m_irr = '0; m_isr = '0; m_imr = '0; m_prio = 0;
        m_base = int'($urandom_range(0, 255));
        wr(2'd1, 32'(m_base));
        for (int it = 0; it < 25; it++) begin
            m_aeoi = ($urandom_range(0, 1) == 1);
            m_rot  = ($urandom_range(0, 1) == 1);
            wr(2'd3, {29'd0, m_rot, m_aeoi, 1'b0});
            m_imr = N'($urandom) & N'($urandom);
            wr(2'd0, 32'(m_imr));
            if ($urandom_range(0, 3) == 0) begin
                m_prio = int'($urandom_range(0, N - 1));
                wr(2'd2, 32'h4 | (32'(m_prio) << 8));
            end
            edges = N'($urandom_range(1, (1 << N) - 1));
            pulse_irq(edges);
            m_irr = m_irr | edges;
            for (int s = 0; s < N + 1; s++) begin
                id = m_best();
                if (id < 0) break;
                wait_int(4, ok);
                total++;
                if (!ok) begin bad++; $display("FAIL rnd_int it=%0d: got int_out=0 want 1", it); end
                e0 = eoi_cnt;
                ack();
                ack();
                m_irr[id] = 1'b0;
                m_isr[id] = 1'b1;
                expv = (m_base / N) * N + id;
                total++;
                if (vec_out !== VW'(expv)) begin bad++; $display("FAIL rnd_vec it=%0d: got %h want %h", it, vec_out, VW'(expv)); end
                if (m_aeoi) begin
                    m_clear(id);
                end else if ($urandom_range(0, 1) == 1) begin
                    wr(2'd2, 32'h1);
                    m_eoi_ns();
                end else begin
                    wr(2'd2, 32'h2 | (32'(id) << 8));
                    m_clear(id);
                end
                tick(2);
                total++;
                if (eoi_cnt - e0 != 1) begin bad++; $display("FAIL rnd_eoi it=%0d: got %0d pulses want 1", it, eoi_cnt - e0); end
            end
            tick(3);
            total++;
            if (int_out !== 1'b0) begin bad++; $display("FAIL rnd_idle it=%0d: got int_out=%b want 0", it, int_out); end
            rd(2'd0, d);
            total++;
            if (d !== 32'(m_irr)) begin bad++; $display("FAIL rnd_irr it=%0d: got %h want %h", it, d, 32'(m_irr)); end
            rd(2'd1, d);
            total++;
            if (d !== 32'(m_isr)) begin bad++; $display("FAIL rnd_isr it=%0d: got %h want %h", it, d, 32'(m_isr)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nested_eoi();
        test_mask();
        test_rotate_aeoi();
        test_nested();
        test_spurious();
        test_reset_mid();
        test_poll();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
